// File: rtl/fetch_redirect_if.sv
// Fetch-side bundle: hazard controls, branch redirect, instruction-memory
// handshake and the IF/ID register outputs.
interface fetch_redirect_if;
    // hazard unit
    logic        stall_f;
    logic        stall_d;
    logic        fetch_busy;
    // branch resolution
    logic        pc_src_d;
    logic [31:0] pc_branch_d;
    // instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    // IF/ID register
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    // fetch unit: drives memory requests and IF/ID
    modport master (
        input  stall_f, stall_d, pc_src_d, pc_branch_d, imem_ready, imem_rdata,
        output imem_req, imem_addr, instr_d, pc_plus4_d, valid_d, fetch_busy
    );

    // environment: memory, hazard unit and execute path
    modport slave (
        output stall_f, stall_d, pc_src_d, pc_branch_d, imem_ready, imem_rdata,
        input  imem_req, imem_addr, instr_d, pc_plus4_d, valid_d, fetch_busy
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC / fetch controller with branch redirect, a valid/ready
// instruction-memory handshake and a 1-entry skid buffer in front of IF/ID.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_redirect_if.master bus
);

    // architectural fetch PC and request tracking
    logic [31:0] pc_f_q, pc_f_d;
    logic        outstanding_q, outstanding_d;
    // redirect that arrived while a request was stuck in memory
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    // skid buffer catching a response that lands during a decode stall
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    // IF/ID register
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] branch_tgt;
    logic [31:0] pc_plus4;
    logic        req;
    logic        complete;

    assign branch_tgt = {bus.pc_branch_d[31:2], 2'b00};
    assign pc_plus4   = pc_f_q + 32'd4;   // wraps naturally at 2^32

    // Once a request is outstanding it must stay up with a stable address.
    // A new request is held off while the skid still owns a word. Gated by
    // rst_n so the request drops immediately when reset asserts.
    assign req      = rst_n & (outstanding_q | (!bus.stall_f & !skid_valid_q));
    assign complete = req & bus.imem_ready;

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_f_q;
    assign bus.instr_d    = instr_q;
    assign bus.pc_plus4_d = pc4_q;
    assign bus.valid_d    = valid_q;
    assign bus.fetch_busy = (outstanding_q & !bus.imem_ready) | skid_valid_q;

    // next-state: redirect > pending-redirect completion > stall/advance
    always_comb begin
        pc_f_d        = pc_f_q;
        outstanding_d = outstanding_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc4_d    = skid_pc4_q;
        instr_d       = instr_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;

        if (bus.pc_src_d) begin
            // flush IF/ID and skid even under a decode stall
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            if (outstanding_q && !bus.imem_ready) begin
                // cannot move the address of a live request; remember the
                // target (newest wins) and drop the response when it arrives
                redir_pend_d = 1'b1;
                redir_tgt_d  = branch_tgt;
            end else begin
                // any response completing this cycle belongs to the wrong path
                pc_f_d        = branch_tgt;
                outstanding_d = 1'b0;
                redir_pend_d  = 1'b0;
            end
        end else if (redir_pend_q && complete) begin
            // stale response retires; only now can the PC jump
            pc_f_d        = redir_tgt_q;
            redir_pend_d  = 1'b0;
            outstanding_d = 1'b0;
            if (!bus.stall_d) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end else begin
            if (complete) begin
                pc_f_d        = pc_plus4;
                outstanding_d = 1'b0;
            end else if (req) begin
                outstanding_d = 1'b1;
            end

            if (bus.stall_d) begin
                // IF/ID holds; a landing word parks in the skid
                if (complete) begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = bus.imem_rdata;
                    skid_pc4_d   = pc_plus4;
                end
            end else if (skid_valid_q) begin
                // no request can complete while the skid is full, so draining
                // it never collides with a fresh response
                instr_d      = skid_instr_q;
                pc4_d        = skid_pc4_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end else if (complete) begin
                instr_d = bus.imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // state registers; reset abandons any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q        <= RESET_PC;
            outstanding_q <= 1'b0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc4_q    <= 32'h0;
            instr_q       <= NOP_INSTR;
            pc4_q         <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            pc_f_q        <= pc_f_d;
            outstanding_q <= outstanding_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc4_q    <= skid_pc4_d;
            instr_q       <= instr_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit. Memory returns addr ^ 32'h1234_0000
// unless an override word is forced.
module tb_fetch_redirect_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic        ovr_en;
    logic [31:0] ovr_word;

    fetch_redirect_if bus();

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_rdata = ovr_en ? ovr_word : (bus.imem_addr ^ 32'h1234_0000);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ovr_en = 1'b0;
        ovr_word = 32'h0;
        rst_n = 1'b0;
        bus.stall_f = 1'b0;
        bus.stall_d = 1'b0;
        bus.pc_src_d = 1'b0;
        bus.pc_branch_d = 32'h0;
        bus.imem_ready = 1'b1;

        // reset state
        tick(); tick();
        chk("rst_valid", {31'b0, bus.valid_d}, 32'd0);
        chk("rst_instr", bus.instr_d, 32'h0);
        chk("rst_pc4", bus.pc_plus4_d, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_busy", {31'b0, bus.fetch_busy}, 32'd0);

        // 1: streaming with ready tied high
        rst_n = 1'b1;
        #1;
        chk("t1_addr0", bus.imem_addr, 32'h0);
        chk("t1_req0", {31'b0, bus.imem_req}, 32'd1);
        tick();
        chk("t1_addr4", bus.imem_addr, 32'h4);
        chk("t1_valid", {31'b0, bus.valid_d}, 32'd1);
        chk("t1_instr0", bus.instr_d, 32'h1234_0000);
        chk("t1_pc4_4", bus.pc_plus4_d, 32'h4);
        tick();
        chk("t1_addr8", bus.imem_addr, 32'h8);
        chk("t1_pc4_8", bus.pc_plus4_d, 32'h8);
        tick();
        chk("t1_addrC", bus.imem_addr, 32'hC);
        chk("t1_pc4_C", bus.pc_plus4_d, 32'hC);
        chk("t1_instr8", bus.instr_d, 32'h1234_0008);

        // 2: taken branch to 0x100, same-cycle completion discarded
        bus.pc_src_d = 1'b1;
        bus.pc_branch_d = 32'h100;
        tick();
        bus.pc_src_d = 1'b0;
        chk("t2_addr", bus.imem_addr, 32'h100);
        chk("t2_bubble", {31'b0, bus.valid_d}, 32'd0);
        chk("t2_nop", bus.instr_d, 32'h0);
        tick();
        chk("t2_instr", bus.instr_d, 32'h1234_0100);
        chk("t2_pc4", bus.pc_plus4_d, 32'h104);
        chk("t2_valid", {31'b0, bus.valid_d}, 32'd1);

        // 3: redirect while a request is stuck at 0x8
        bus.pc_src_d = 1'b1;
        bus.pc_branch_d = 32'h8;
        tick();
        bus.pc_src_d = 1'b0;
        bus.imem_ready = 1'b0;
        chk("t3_addr8", bus.imem_addr, 32'h8);
        tick();                                   // wait cycle 1
        chk("t3_hold1", bus.imem_addr, 32'h8);
        bus.pc_src_d = 1'b1;
        bus.pc_branch_d = 32'h40;
        #1;
        chk("t3_busy", {31'b0, bus.fetch_busy}, 32'd1);
        tick();                                   // wait cycle 2, redirect latched
        bus.pc_src_d = 1'b0;
        chk("t3_hold2", bus.imem_addr, 32'h8);
        chk("t3_req", {31'b0, bus.imem_req}, 32'd1);
        tick();                                   // wait cycle 3
        chk("t3_hold3", bus.imem_addr, 32'h8);
        bus.imem_ready = 1'b1;
        tick();                                   // stale response retires
        chk("t3_redir", bus.imem_addr, 32'h40);
        chk("t3_discard", {31'b0, bus.valid_d}, 32'd0);
        tick();
        chk("t3_instr40", bus.instr_d, 32'h1234_0040);
        chk("t3_addr44", bus.imem_addr, 32'h44);

        // 4: response lands during decode stall -> skid
        ovr_en = 1'b1;
        ovr_word = 32'hDEAD_BEEF;
        bus.stall_d = 1'b1;
        tick();
        ovr_en = 1'b0;
        chk("t4_hold", bus.instr_d, 32'h1234_0040);
        chk("t4_busy", {31'b0, bus.fetch_busy}, 32'd1);
        chk("t4_noreq", {31'b0, bus.imem_req}, 32'd0);
        tick();
        chk("t4_hold2", bus.instr_d, 32'h1234_0040);
        chk("t4_addr", bus.imem_addr, 32'h48);
        bus.stall_d = 1'b0;
        tick();
        chk("t4_drain", bus.instr_d, 32'hDEAD_BEEF);
        chk("t4_pc4", bus.pc_plus4_d, 32'h48);
        chk("t4_idle", {31'b0, bus.fetch_busy}, 32'd0);
        tick();
        chk("t4_resume", bus.instr_d, 32'h1234_0048);

        // 5: PC wrap and target alignment
        bus.pc_src_d = 1'b1;
        bus.pc_branch_d = 32'hFFFF_FFFC;
        tick();
        bus.pc_src_d = 1'b0;
        chk("t5_top", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_wrap", bus.imem_addr, 32'h0);
        chk("t5_pc4", bus.pc_plus4_d, 32'h0);
        chk("t5_instr", bus.instr_d, 32'hEDCB_FFFC);
        bus.pc_src_d = 1'b1;
        bus.pc_branch_d = 32'h103;
        tick();
        bus.pc_src_d = 1'b0;
        chk("t5_align", bus.imem_addr, 32'h100);
        tick();
        chk("t5_valid", {31'b0, bus.valid_d}, 32'd1);

        // 6: async reset during an outstanding request
        bus.stall_d = 1'b1;
        bus.imem_ready = 1'b0;
        tick();
        chk("t6_out", bus.imem_addr, 32'h104);
        chk("t6_vhold", {31'b0, bus.valid_d}, 32'd1);
        bus.stall_d = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'b0, bus.valid_d}, 32'd0);
        chk("t6_instr", bus.instr_d, 32'h0);
        chk("t6_pc4", bus.pc_plus4_d, 32'h0);
        chk("t6_addr", bus.imem_addr, 32'h0);
        chk("t6_req", {31'b0, bus.imem_req}, 32'd0);
        chk("t6_busy", {31'b0, bus.fetch_busy}, 32'd0);
        tick();
        bus.stall_f = 1'b1;
        bus.imem_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("t6_stale_addr", bus.imem_addr, 32'h0);
        chk("t6_stale_valid", {31'b0, bus.valid_d}, 32'd0);
        bus.stall_f = 1'b0;
        tick();
        chk("t6_fetch_addr", bus.imem_addr, 32'h4);
        chk("t6_fetch_instr", bus.instr_d, 32'h1234_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
